// File: rtl/ir_nec_rx.sv
// ir_nec_rx: NEC IR frame receiver measuring filtered pulse/space durations on an oversampled tick grid.
// Reports command/address on valid, repeat codes on repeat_, and aborted or rejected frames on error.
module ir_nec_rx #(
    parameter int TICK_DIV  = 3516,
    parameter int OS        = 8,
    parameter int FILT      = 2,
    parameter bit EXT_ADDR  = 1'b0,
    parameter bit IN_INVERT = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        signal,
    output logic [7:0]  value,
    output logic [15:0] address,
    output logic        valid,
    output logic        repeat_,
    output logic        error,
    output logic        busy
);
    localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int FW = $clog2(FILT + 1);
    localparam int IW = $clog2(256 * OS + 1);
    localparam logic SPACE_RAW = !IN_INVERT;
    localparam logic [IW-1:0] IDLE_MAX = IW'(256 * OS);
    localparam logic [8:0] LB_LO = 9'(12 * OS), LB_HI = 9'(20 * OS);
    localparam logic [8:0] LS_LO = 9'(6 * OS),  LS_HI = 9'(10 * OS);
    localparam logic [8:0] RS_LO = 9'(3 * OS),  RS_HI = 9'(5 * OS);
    localparam logic [8:0] B_LO  = 9'(OS / 2),  B_HI  = 9'(3 * OS / 2);
    localparam logic [8:0] S0_LO = 9'(OS / 2),  S0_HI = 9'(2 * OS - 1);
    localparam logic [8:0] S1_LO = 9'(2 * OS),  S1_HI = 9'(4 * OS);

    typedef enum logic [2:0] {IDLE, LEAD_BURST, LEAD_SPACE, BIT_BURST, BIT_SPACE, STOP_BURST, CHECK} state_t;

    state_t          state_q, state_d;
    logic [1:0]      sync_q, sync_d;
    logic [DW-1:0]   div_q, div_d;
    logic            filt_q, filt_d;
    logic [FW-1:0]   fcnt_q, fcnt_d;
    logic [8:0]      dur_q, dur_d;
    logic [4:0]      bit_q, bit_d;
    logic [31:0]     sr_q, sr_d;
    logic            rpt_q, rpt_d;
    logic            rpt_ok_q, rpt_ok_d;
    logic [IW-1:0]   idle_q, idle_d;
    logic [7:0]      value_q, value_d;
    logic [15:0]     address_q, address_d;
    logic            valid_q, valid_d, repeat_q, repeat_d, error_q, error_d, busy_q, busy_d;
    logic            tick, inb, edge_ev, rise, fall, err;
    logic            lb, ls, rs, bw, s0, s1, cmd_ok, addr_ok;

    function automatic logic win(input logic [8:0] d, input logic [8:0] lo, input logic [8:0] hi);
        return (d >= lo) && (d <= hi);
    endfunction

    assign tick    = div_q == DW'(TICK_DIV - 1);
    assign inb     = sync_q[1] ^ SPACE_RAW;
    assign edge_ev = tick && (inb != filt_q) && (fcnt_q == FW'(FILT - 1));
    assign rise    = edge_ev && inb;
    assign fall    = edge_ev && !inb;
    assign lb      = win(dur_q, LB_LO, LB_HI);
    assign ls      = win(dur_q, LS_LO, LS_HI);
    assign rs      = win(dur_q, RS_LO, RS_HI);
    assign bw      = win(dur_q, B_LO, B_HI);
    assign s0      = win(dur_q, S0_LO, S0_HI);
    assign s1      = win(dur_q, S1_LO, S1_HI);
    assign cmd_ok  = sr_q[23:16] == ~sr_q[31:24];
    assign addr_ok = EXT_ADDR || (sr_q[15:8] == ~sr_q[7:0]);

    always_comb begin
        sync_d    = {sync_q[0], signal};
        div_d     = tick ? '0 : div_q + 1'b1;
        filt_d    = edge_ev ? inb : filt_q;
        fcnt_d    = !tick ? fcnt_q : (inb == filt_q || edge_ev) ? '0 : fcnt_q + 1'b1;
        // Edges see the pre-increment duration, then restart the measurement.
        dur_d     = edge_ev ? '0 : (tick && dur_q != 9'h1FF) ? dur_q + 1'b1 : dur_q;
        state_d   = state_q;
        bit_d     = bit_q;
        sr_d      = sr_q;
        rpt_d     = rpt_q;
        rpt_ok_d  = rpt_ok_q;
        value_d   = value_q;
        address_d = address_q;
        valid_d   = 1'b0;
        repeat_d  = 1'b0;
        err       = 1'b0;
        case (state_q)
            IDLE:       state_d = rise ? LEAD_BURST : IDLE;
            LEAD_BURST: if (fall) begin
                state_d = lb ? LEAD_SPACE : IDLE;
                err     = !lb;
            end
            LEAD_SPACE: if (rise) begin
                state_d = ls ? BIT_BURST : rs ? STOP_BURST : IDLE;
                bit_d   = '0;
                rpt_d   = rs;
                err     = !ls && !rs;
            end
            BIT_BURST: if (fall) begin
                state_d = bw ? BIT_SPACE : IDLE;
                err     = !bw;
            end
            BIT_SPACE: if (rise) begin
                state_d = !(s0 || s1) ? IDLE : (bit_q == 5'd31) ? STOP_BURST : BIT_BURST;
                sr_d    = {s1, sr_q[31:1]};
                bit_d   = bit_q + 1'b1;
                err     = !(s0 || s1);
            end
            STOP_BURST: if (fall) begin
                state_d = bw ? CHECK : IDLE;
                err     = !bw;
            end
            CHECK: begin
                state_d = IDLE;
                if (rpt_q) begin
                    repeat_d = rpt_ok_q;
                    err      = !rpt_ok_q;
                end else if (cmd_ok && addr_ok) begin
                    valid_d   = 1'b1;
                    value_d   = sr_q[23:16];
                    address_d = sr_q[15:0];
                    rpt_ok_d  = 1'b1;
                end else begin
                    err = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // A level stuck long enough to saturate the counter aborts the frame.
        if (state_q != IDLE && state_q != CHECK && dur_q == 9'h1FF) begin
            state_d = IDLE;
            err     = 1'b1;
        end
        idle_d   = (state_q != IDLE) ? '0 : (tick && idle_q != IDLE_MAX) ? idle_q + 1'b1 : idle_q;
        rpt_ok_d = (err || idle_q == IDLE_MAX) ? 1'b0 : rpt_ok_d;
        error_d  = err;
        busy_d   = state_d != IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            sync_q    <= {2{SPACE_RAW}};
            div_q     <= '0;
            filt_q    <= 1'b0;
            fcnt_q    <= '0;
            dur_q     <= '0;
            bit_q     <= '0;
            sr_q      <= '0;
            rpt_q     <= 1'b0;
            rpt_ok_q  <= 1'b0;
            idle_q    <= '0;
            value_q   <= '0;
            address_q <= '0;
            valid_q   <= 1'b0;
            repeat_q  <= 1'b0;
            error_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            div_q     <= div_d;
            filt_q    <= filt_d;
            fcnt_q    <= fcnt_d;
            dur_q     <= dur_d;
            bit_q     <= bit_d;
            sr_q      <= sr_d;
            rpt_q     <= rpt_d;
            rpt_ok_q  <= rpt_ok_d;
            idle_q    <= idle_d;
            value_q   <= value_d;
            address_q <= address_d;
            valid_q   <= valid_d;
            repeat_q  <= repeat_d;
            error_q   <= error_d;
            busy_q    <= busy_d;
        end
    end

    assign value   = value_q;
    assign address = address_q;
    assign valid   = valid_q;
    assign repeat_ = repeat_q;
    assign error   = error_q;
    assign busy    = busy_q;
endmodule

// File: tb/tb_ir_nec_rx.sv
// tb_ir_nec_rx: drives NEC waveforms into a checked-address and an extended-address receiver
// and compares pulses and outputs against a frame-level model of the protocol.
module tb_ir_nec_rx;
    localparam int TD = 4;
    localparam int OS = 8;
    localparam int U  = TD * OS;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic signal = 1'b1;
    logic [7:0]  val0, val1;
    logic [15:0] adr0, adr1;
    logic v0, v1, r0, r1, e0, e1, b0, b1;

    int checks = 0;
    int errors = 0;
    int nv[2] = '{0, 0};
    int nr[2] = '{0, 0};
    int ne[2] = '{0, 0};
    int sv[2], srp[2], se[2];
    int ev[2], er[2], ee[2];
    logic [7:0]  m_val[2] = '{8'h00, 8'h00};
    logic [15:0] m_adr[2] = '{16'h0000, 16'h0000};
    bit          m_rpt[2] = '{1'b0, 1'b0};

    ir_nec_rx #(.TICK_DIV(TD), .OS(OS), .FILT(2), .EXT_ADDR(1'b0), .IN_INVERT(1'b0)) dut (
        .clk(clk), .reset(reset), .signal(signal), .value(val0), .address(adr0),
        .valid(v0), .repeat_(r0), .error(e0), .busy(b0));

    ir_nec_rx #(.TICK_DIV(TD), .OS(OS), .FILT(2), .EXT_ADDR(1'b1), .IN_INVERT(1'b0)) dut_x (
        .clk(clk), .reset(reset), .signal(signal), .value(val1), .address(adr1),
        .valid(v1), .repeat_(r1), .error(e1), .busy(b1));

    always #5 clk = ~clk;

    // Counting high cycles (not pulses) also catches stretched pulses.
    always @(negedge clk) begin
        if (v0) nv[0]++;
        if (v1) nv[1]++;
        if (r0) nr[0]++;
        if (r1) nr[1]++;
        if (e0) ne[0]++;
        if (e1) ne[1]++;
    end

    function automatic logic [36:0] obs(input int k);
        return {4'(nv[k] - sv[k]), 4'(nr[k] - srp[k]), 4'(ne[k] - se[k]),
                k == 1 ? val1 : val0, k == 1 ? adr1 : adr0, k == 1 ? b1 : b0};
    endfunction

    function automatic logic [36:0] expv(input int k);
        return {4'(ev[k]), 4'(er[k]), 4'(ee[k]), m_val[k], m_adr[k], 1'b0};
    endfunction

    task automatic snap();
        for (int k = 0; k < 2; k++) begin
            sv[k] = nv[k]; srp[k] = nr[k]; se[k] = ne[k];
            ev[k] = 0; er[k] = 0; ee[k] = 0;
        end
    endtask

    task automatic exp_frame(input logic [31:0] w);
        for (int k = 0; k < 2; k++) begin
            if (w[23:16] == ~w[31:24] && (k == 1 || w[15:8] == ~w[7:0])) begin
                ev[k]++; m_val[k] = w[23:16]; m_adr[k] = w[15:0]; m_rpt[k] = 1'b1;
            end else begin
                ee[k]++; m_rpt[k] = 1'b0;
            end
        end
    endtask

    task automatic exp_repeat();
        for (int k = 0; k < 2; k++) begin
            if (m_rpt[k]) er[k]++;
            else ee[k]++;
        end
    endtask

    task automatic exp_error();
        for (int k = 0; k < 2; k++) begin
            ee[k]++; m_rpt[k] = 1'b0;
        end
    endtask

    task automatic seg(input logic lvl, input int cyc);
        signal = lvl;
        repeat (cyc) @(negedge clk);
    endtask

    task automatic send_frame(input logic [31:0] w, input int nbits, input int gbit);
        seg(1'b0, 16 * U);
        seg(1'b1, 8 * U);
        for (int i = 0; i < nbits; i++) begin
            seg(1'b0, U + int'($urandom_range(0, 3)));
            if (i == gbit) begin
                seg(1'b1, 12);
                seg(1'b0, 4);
                seg(1'b1, (w[i] ? 3 * U : U) - 16);
            end else begin
                seg(1'b1, (w[i] ? 3 * U : U) + int'($urandom_range(0, 3)));
            end
        end
        if (nbits == 32) seg(1'b0, U);
        signal = 1'b1;
    endtask

    task automatic send_repeat();
        seg(1'b0, 16 * U);
        seg(1'b1, 4 * U);
        seg(1'b0, U);
        signal = 1'b1;
    endtask

    function automatic logic [31:0] mk(input logic [7:0] a1, input logic [7:0] a2, input logic [7:0] c);
        return {~c, c, a2, a1};
    endfunction

    task automatic test_reset();
        repeat (10) @(negedge clk);
        checks++;
        if ({val0, adr0, v0, r0, e0, b0} !== 28'h0) begin
            errors++; $display("FAIL reset inst0: got %h, expected 0", {val0, adr0, v0, r0, e0, b0});
        end
        checks++;
        if ({val1, adr1, v1, r1, e1, b1} !== 28'h0) begin
            errors++; $display("FAIL reset inst1: got %h, expected 0", {val1, adr1, v1, r1, e1, b1});
        end
        reset = 1'b1;
        seg(1'b1, 4 * U);
    endtask

    task automatic test_frame();
        logic [31:0] w = mk(8'h00, 8'hFF, 8'h45);
        snap();
        send_frame(w, 32, -1);
        exp_frame(w);
        seg(1'b1, 4 * U);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs(k) !== expv(k)) begin
                errors++; $display("FAIL frame45 inst%0d: got %h, expected %h", k, obs(k), expv(k));
            end
        end
    endtask

    task automatic test_repeat();
        seg(1'b1, 50 * U);
        snap();
        send_repeat();
        exp_repeat();
        seg(1'b1, 4 * U);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs(k) !== expv(k)) begin
                errors++; $display("FAIL repeat_ok inst%0d: got %h, expected %h", k, obs(k), expv(k));
            end
        end
        seg(1'b1, 300 * U);
        m_rpt[0] = 1'b0;
        m_rpt[1] = 1'b0;
        snap();
        send_repeat();
        exp_repeat();
        seg(1'b1, 4 * U);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs(k) !== expv(k)) begin
                errors++; $display("FAIL repeat_late inst%0d: got %h, expected %h", k, obs(k), expv(k));
            end
        end
    endtask

    task automatic test_bad_cmd();
        logic [31:0] w = {8'hBB, 8'h45, 8'hFF, 8'h00};
        snap();
        send_frame(w, 32, -1);
        exp_frame(w);
        seg(1'b1, 4 * U);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs(k) !== expv(k)) begin
                errors++; $display("FAIL bad_cmd inst%0d: got %h, expected %h", k, obs(k), expv(k));
            end
        end
    endtask

    task automatic test_ext_addr();
        logic [31:0] w = mk(8'h12, 8'h34, 8'h0C);
        snap();
        send_frame(w, 32, -1);
        exp_frame(w);
        seg(1'b1, 4 * U);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs(k) !== expv(k)) begin
                errors++; $display("FAIL ext_addr inst%0d: got %h, expected %h", k, obs(k), expv(k));
            end
        end
    endtask

    task automatic test_glitch();
        logic [31:0] w = mk(8'h5A, 8'hA5, 8'h3C);
        snap();
        send_frame(w, 32, 9);
        exp_frame(w);
        seg(1'b1, 4 * U);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs(k) !== expv(k)) begin
                errors++; $display("FAIL glitch inst%0d: got %h, expected %h", k, obs(k), expv(k));
            end
        end
    endtask

    task automatic test_short_leader();
        snap();
        seg(1'b0, 8 * U);
        seg(1'b1, 8 * U);
        exp_error();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs(k) !== expv(k)) begin
                errors++; $display("FAIL short_leader inst%0d: got %h, expected %h", k, obs(k), expv(k));
            end
        end
    endtask

    task automatic test_timeout();
        snap();
        seg(1'b0, 70 * U);
        seg(1'b1, 4 * U);
        exp_error();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs(k) !== expv(k)) begin
                errors++; $display("FAIL timeout inst%0d: got %h, expected %h", k, obs(k), expv(k));
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] w = mk(8'h21, 8'hDE, 8'h77);
        send_frame(w, 10, -1);
        reset = 1'b0;
        signal = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({val0, adr0, v0, r0, e0, b0} !== 28'h0) begin
            errors++; $display("FAIL reset_mid inst0: got %h, expected 0", {val0, adr0, v0, r0, e0, b0});
        end
        checks++;
        if ({val1, adr1, v1, r1, e1, b1} !== 28'h0) begin
            errors++; $display("FAIL reset_mid inst1: got %h, expected 0", {val1, adr1, v1, r1, e1, b1});
        end
        for (int k = 0; k < 2; k++) begin
            m_val[k] = 8'h00; m_adr[k] = 16'h0000; m_rpt[k] = 1'b0;
        end
        repeat (5) @(negedge clk);
        reset = 1'b1;
        seg(1'b1, 10 * U);
        snap();
        send_frame(w, 32, -1);
        exp_frame(w);
        seg(1'b1, 4 * U);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs(k) !== expv(k)) begin
                errors++; $display("FAIL after_reset inst%0d: got %h, expected %h", k, obs(k), expv(k));
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 4; n++) begin
            logic [7:0] a1 = 8'($urandom);
            logic [7:0] c  = 8'($urandom);
            logic [31:0] w = mk(a1, ~a1, c);
            int mode = int'($urandom_range(0, 2));
            if (mode == 1) w[15:8] = 8'($urandom);
            if (mode == 2) w[31:24] = ~c ^ 8'($urandom_range(1, 255));
            snap();
            send_frame(w, 32, -1);
            exp_frame(w);
            seg(1'b1, 4 * U);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs(k) !== expv(k)) begin
                    errors++; $display("FAIL rand_frame%0d inst%0d: got %h, expected %h", n, k, obs(k), expv(k));
                end
            end
            seg(1'b1, int'($urandom_range(20, 100)) * U);
            snap();
            send_repeat();
            exp_repeat();
            seg(1'b1, 4 * U);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs(k) !== expv(k)) begin
                    errors++; $display("FAIL rand_repeat%0d inst%0d: got %h, expected %h", n, k, obs(k), expv(k));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_repeat();
        test_bad_cmd();
        test_ext_addr();
        test_glitch();
        test_short_leader();
        test_timeout();
        test_reset_mid_frame();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
